// File: rtl/pkt_reader_pkg.sv
// Shared definitions for the packet reader: FSM state encoding and the
// location of the payload-length field inside a header word.
package pkt_reader_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  // Length field occupies header bits [HDR_LEN_LSB +: LEN_W].
  localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/pkt_out_reg.sv
// Single-stage valid/ready output holding register. A load always wins;
// otherwise the word is held until the downstream accepts it.
module pkt_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
      last_d  = i_last;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains length-prefixed packets from a show-ahead FIFO and presents the
// payload words on a valid/ready stream, counting completed packets.
module fifo_pkt_reader
  import pkt_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_q,
  output logic             o_fifo_rdreq,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready,
  output logic [LEN_W-1:0] o_len,
  output logic             o_busy,
  output logic             o_err,
  output logic [15:0]      o_pkt_cnt
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0] hdr_len;
  logic             pop;
  logic             load;
  logic             load_last;
  logic             rem_is_one;

  assign hdr_len    = i_fifo_q[HDR_LEN_LSB +: LEN_W];
  assign rem_is_one = (rem_q == LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_d     = len_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Headers may pop while the previous last word is still held.
        pop = !i_fifo_empty;
        if (pop) begin
          len_d = hdr_len;
          rem_d = hdr_len;
          if (hdr_len != '0) state_d = ST_PAYLOAD;
          else               err_d   = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        pop = !i_fifo_empty && (!o_valid || i_ready);
        if (pop) begin
          load      = 1'b1;
          load_last = rem_is_one;
          rem_d     = rem_q - LEN_W'(1);
          if (rem_is_one) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (o_valid && i_ready && o_last) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  pkt_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load),
    .i_data  (i_fifo_q),
    .i_last  (load_last),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last)
  );

  // The pop request is combinational, so gate it directly while in reset.
  assign o_fifo_rdreq = pop && i_rst_n;
  assign o_len        = len_q;
  assign o_busy       = (state_q != ST_IDLE) || o_valid;
  assign o_err        = err_q;
  assign o_pkt_cnt    = cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader: FIFO model, output scoreboard,
// a table of single-packet vectors and hand-written corner-case sequences.
module tb_fifo_pkt_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_q;
  logic        rdreq;
  logic        valid;
  logic [31:0] data;
  logic        last;
  logic        ready;
  logic [9:0]  len;
  logic        busy;
  logic        err;
  logic [15:0] pkt_cnt;

  fifo_pkt_reader #(.WIDTH(32), .LEN_W(10)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_q     (fifo_q),
    .o_fifo_rdreq (rdreq),
    .o_valid      (valid),
    .o_data       (data),
    .o_last       (last),
    .i_ready      (ready),
    .o_len        (len),
    .o_busy       (busy),
    .o_err        (err),
    .o_pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int n;
    bit rnd_ready;
    int exp_pops;
    int cnt_inc;
    int exp_err;
  } vec_t;

  logic [31:0] fq[$];
  exp_t        sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int xfers = 0;
  int err_seen = 0;
  int first_pop, last_pop, first_xfer, last_xfer;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_q     = (fq.size() == 0) ? 32'h0 : fq[0];
  endtask

  task automatic push_hdr(input int n);
    logic [31:0] w;
    w = ($urandom & 32'hFFFF_FC00) | 32'(n);
    fq.push_back(w);
    refresh();
  endtask

  task automatic push_word(input logic [31:0] w, input logic is_last);
    exp_t e;
    fq.push_back(w);
    e.data = w;
    e.last = is_last;
    sb.push_back(e);
    refresh();
  endtask

  task automatic clr_track();
    first_pop = -1; last_pop = -1; first_xfer = -1; last_xfer = -1;
  endtask

  // One clock: check outputs at negedge, capture the pop at posedge, update FIFO after.
  task automatic step();
    logic p;
    exp_t e;
    @(negedge clk);
    check("rdreq_while_empty", {63'b0, rdreq & fifo_empty}, 64'd0);
    if (err) err_seen++;
    if (valid && ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word: got %0h expected none", data);
      end else begin
        e = sb.pop_front();
        check("out_word", {31'b0, last, data}, {31'b0, e.last, e.data});
      end
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      xfers++;
    end
    @(posedge clk);
    p = rdreq;
    #1;
    if (p) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL fifo_underflow: got pop expected none");
      end else begin
        void'(fq.pop_front());
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
    cyc++;
    refresh();
  endtask

  task automatic run(input bit rnd);
    int k = 0;
    while (!(fq.size() == 0 && sb.size() == 0 && !busy) && k < 300) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    if (k >= 300) begin
      total++; bad++;
      $display("FAIL run_timeout: got %0d cycles expected fewer than 300", k);
    end
    ready = 1'b1;
    step();
    step();
  endtask

  vec_t tbl[5];

  initial begin
    int p0, e0, x0;
    logic [31:0] a_word;
    tbl[0] = '{n: 2, rnd_ready: 1'b0, exp_pops: 3, cnt_inc: 1, exp_err: 0};
    tbl[1] = '{n: 1, rnd_ready: 1'b1, exp_pops: 2, cnt_inc: 1, exp_err: 0};
    tbl[2] = '{n: 0, rnd_ready: 1'b0, exp_pops: 1, cnt_inc: 0, exp_err: 1};
    tbl[3] = '{n: 6, rnd_ready: 1'b1, exp_pops: 7, cnt_inc: 1, exp_err: 0};
    tbl[4] = '{n: 3, rnd_ready: 1'b1, exp_pops: 4, cnt_inc: 1, exp_err: 0};

    // Reset state, and no pop request during reset even with data present
    rst_n = 1'b0; ready = 1'b1; clr_track(); refresh();
    #12;
    check("rst_valid", {63'b0, valid}, 64'd0);
    check("rst_data", {32'b0, data}, 64'd0);
    check("rst_last", {63'b0, last}, 64'd0);
    check("rst_len", {54'b0, len}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_cnt", {48'b0, pkt_cnt}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    push_hdr(1);
    #1;
    check("rst_rdreq", {63'b0, rdreq}, 64'd0);
    void'(fq.pop_front()); refresh();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Table-driven single packets
    for (int v = 0; v < 5; v++) begin
      p0 = pops; e0 = err_seen;
      push_hdr(tbl[v].n);
      for (int j = 0; j < tbl[v].n; j++) push_word($urandom, j == tbl[v].n - 1);
      run(tbl[v].rnd_ready);
      exp_cnt += tbl[v].cnt_inc;
      check("vec_pops", 64'(pops - p0), 64'(tbl[v].exp_pops));
      check("vec_err", 64'(err_seen - e0), 64'(tbl[v].exp_err));
      check("vec_len", {54'b0, len}, 64'(tbl[v].n));
      check("vec_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));
    end

    // N=3 at full rate: 4 pops back to back, 3 words back to back
    clr_track(); p0 = pops; x0 = xfers; ready = 1'b1;
    push_hdr(3);
    push_word(32'hA0A0_0001, 1'b0);
    push_word(32'hB0B0_0002, 1'b0);
    push_word(32'hC0C0_0003, 1'b1);
    run(1'b0);
    exp_cnt += 1;
    check("burst_pops", 64'(pops - p0), 64'd4);
    check("burst_pop_span", 64'(last_pop - first_pop), 64'd3);
    check("burst_xfers", 64'(xfers - x0), 64'd3);
    check("burst_xfer_span", 64'(last_xfer - first_xfer), 64'd2);
    check("burst_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));

    // Backpressure: A held for 5 cycles, no pops, B follows when ready rises
    a_word = 32'h1111_AAAA;
    push_hdr(3);
    push_word(a_word, 1'b0);
    push_word(32'h2222_BBBB, 1'b0);
    push_word(32'h3333_CCCC, 1'b1);
    for (int k = 0; k < 20 && !valid; k++) step();
    check("hold_valid_seen", {63'b0, valid}, 64'd1);
    ready = 1'b0; p0 = pops;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_valid", {63'b0, valid}, 64'd1);
      check("hold_data", {32'b0, data}, {32'b0, a_word});
    end
    check("hold_no_pop", 64'(pops - p0), 64'd0);
    ready = 1'b1;
    step();
    check("hold_next_b", {31'b0, valid, data}, {31'b0, 1'b1, 32'h2222_BBBB});
    run(1'b0);
    exp_cnt += 1;
    check("hold_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));

    // Zero-length header followed by a one-word packet
    e0 = err_seen;
    push_hdr(0);
    push_hdr(1);
    push_word(32'hDDDD_0D0D, 1'b1);
    run(1'b0);
    exp_cnt += 1;
    check("zero_err_once", 64'(err_seen - e0), 64'd1);
    check("zero_len", {54'b0, len}, 64'd1);
    check("zero_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));

    // FIFO runs dry after 2 of 4 payload words, refills 3 cycles later
    x0 = xfers;
    push_hdr(4);
    push_word(32'h4000_0001, 1'b0);
    push_word(32'h4000_0002, 1'b0);
    for (int k = 0; k < 4; k++) step();
    p0 = pops;
    for (int k = 0; k < 3; k++) step();
    check("dry_no_pop", 64'(pops - p0), 64'd0);
    check("dry_busy", {63'b0, busy}, 64'd1);
    push_word(32'h4000_0003, 1'b0);
    push_word(32'h4000_0004, 1'b1);
    run(1'b0);
    exp_cnt += 1;
    check("dry_xfers", 64'(xfers - x0), 64'd4);
    check("dry_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));

    // Reset after 2 of 5 payload words; next word is a header
    x0 = xfers;
    push_hdr(5);
    push_word(32'h5000_0001, 1'b0);
    push_word(32'h5000_0002, 1'b0);
    for (int k = 0; k < 20 && (xfers - x0) < 2; k++) step();
    check("mid_xfers", 64'(xfers - x0), 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'b0, valid}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_cnt", {48'b0, pkt_cnt}, 64'd0);
    exp_cnt = 0;
    push_hdr(2);
    #1;
    check("mid_rst_rdreq", {63'b0, rdreq}, 64'd0);
    step();
    rst_n = 1'b1;
    push_word(32'h6000_0001, 1'b0);
    push_word(32'h6000_0002, 1'b1);
    run(1'b0);
    exp_cnt += 1;
    check("mid_new_len", {54'b0, len}, 64'd2);
    check("mid_new_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));

    // Back-to-back N=1 and N=2 packets: 5 pops in 5 cycles
    clr_track(); p0 = pops;
    push_hdr(1);
    push_word(32'h7000_0001, 1'b1);
    push_hdr(2);
    push_word(32'h7000_0002, 1'b0);
    push_word(32'h7000_0003, 1'b1);
    run(1'b0);
    exp_cnt += 2;
    check("b2b_pops", 64'(pops - p0), 64'd5);
    check("b2b_pop_span", 64'(last_pop - first_pop), 64'd4);
    check("b2b_cnt", {48'b0, pkt_cnt}, 64'(exp_cnt));
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
